// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the bus_clk pipe_link processing chain.
package pipe_pkg;

  localparam int unsigned DW_DEF        = 16;
  localparam int unsigned DEPTH_DEF     = 512;
  localparam int unsigned AF_MARGIN_DEF = 8;
  localparam int unsigned GW_DEF        = 6;

  // Width needed to hold a fill level of 0..depth inclusive.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_link_if.sv
// Push-in / valid-ready-out bus between two pipe_link chain stages.
interface pipe_link_if #(
  parameter int unsigned DW = pipe_pkg::DW_DEF
) ();

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_full;
  logic          in_afull;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  // Buffer side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_full, in_afull, out_data, out_valid
  );

  // Upstream producer plus downstream consumer side.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_full, in_afull, out_data, out_valid
  );

endinterface

// File: rtl/pipe_link_mem.sv
// Simple dual-port storage: synchronous write, registered read (old data on same-address collision).
module pipe_link_mem #(
  parameter  int unsigned DW    = 16,
  parameter  int unsigned DEPTH = 512,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pipe_link.sv
// Inter-stage FWFT buffer with group decimation, almost-full warning and sticky overflow.
module pipe_link import pipe_pkg::*; #(
  parameter  int unsigned DW        = DW_DEF,
  parameter  int unsigned DEPTH     = DEPTH_DEF,
  parameter  int unsigned AF_MARGIN = AF_MARGIN_DEF,
  parameter  int unsigned GW        = GW_DEF,
  localparam int unsigned LW        = level_w(DEPTH),
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic          bus_clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [GW-1:0] grp_len,
  pipe_link_if.slave    bus,
  output logic [LW-1:0] level,
  output logic          overflow
);

  localparam int unsigned AF_LVL = DEPTH - AF_MARGIN;

  logic [GW-1:0] gcnt_q, gcnt_d, gcnt_eff;
  logic [LW-1:0] level_q, level_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] out_data_q, out_data_d, fwd_data_q, fwd_data_d;
  logic          out_valid_q, out_valid_d, fwd_v_q, fwd_v_d;
  logic          overflow_q, overflow_d;
  logic          short_grp, kept, full, pop, push;
  logic          ram_empty, head_free, from_ram, from_in, ram_wr;
  logic [DW-1:0] ram_rdata, ram_head;

  // Group position; a shrunk grp_len restarts the group on the next word.
  always_comb begin
    short_grp = (grp_len <= GW'(1));
    gcnt_eff  = (gcnt_q >= grp_len) ? '0 : gcnt_q;
    kept      = bus.in_valid && (short_grp || (gcnt_eff == '0));
    gcnt_d    = gcnt_eff;
    if (short_grp) begin
      gcnt_d = '0;
    end else if (bus.in_valid) begin
      gcnt_d = (gcnt_eff == GW'(grp_len - GW'(1))) ? '0 : GW'(gcnt_eff + GW'(1));
    end
    if (clr) gcnt_d = '0;
  end

  // The head register holds one word; the RAM holds the rest, read one cycle ahead.
  always_comb begin
    full      = (level_q == LW'(DEPTH));
    pop       = out_valid_q && bus.out_ready;
    push      = kept && !full;
    ram_empty = (level_q == LW'(out_valid_q));
    head_free = !out_valid_q || pop;
    from_ram  = head_free && !ram_empty;
    from_in   = head_free && ram_empty && push;
    ram_wr    = push && !from_in;
    ram_head  = fwd_v_q ? fwd_data_q : ram_rdata;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (head_free) out_valid_d = from_ram || from_in;
    if (from_ram)     out_data_d = ram_head;
    else if (from_in) out_data_d = bus.in_data;

    rd_ptr_d = AW'(rd_ptr_q + AW'(from_ram));
    wr_ptr_d = AW'(wr_ptr_q + AW'(ram_wr));

    // A write landing on the slot being read next cycle must bypass the RAM.
    fwd_v_d    = ram_wr && (wr_ptr_q == rd_ptr_d);
    fwd_data_d = bus.in_data;

    level_d = level_q;
    if (push && !pop)      level_d = LW'(level_q + LW'(1));
    else if (pop && !push) level_d = LW'(level_q - LW'(1));

    overflow_d = overflow_q || (kept && full);

    if (clr) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      fwd_v_d     = 1'b0;
      fwd_data_d  = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
    end
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      gcnt_q      <= '0;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      fwd_data_q  <= '0;
      fwd_v_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      gcnt_q      <= gcnt_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      fwd_data_q  <= fwd_data_d;
      fwd_v_q     <= fwd_v_d;
      overflow_q  <= overflow_d;
    end
  end

  pipe_link_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (bus_clk),
    .wr_en   (ram_wr),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.in_data),
    .rd_addr (rd_ptr_d),
    .rd_data (ram_rdata)
  );

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_full   = full;
  assign bus.in_afull  = (level_q >= LW'(AF_LVL));
  assign level         = level_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_pipe_link.sv
// Bench for pipe_link: vector table, directed corner sequences and random traffic against a queue model.
module tb_pipe_link;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFM   = 4;
  localparam int unsigned GW    = 6;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          bus_clk;
  logic          rst;
  logic          clr;
  logic [GW-1:0] grp_len;
  logic [LW-1:0] level;
  logic          overflow;

  pipe_link_if #(.DW(DW)) bus ();

  pipe_link #(
    .DW(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM), .GW(GW)
  ) dut (
    .bus_clk  (bus_clk),
    .rst      (rst),
    .clr      (clr),
    .grp_len  (grp_len),
    .bus      (bus),
    .level    (level),
    .overflow (overflow)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  int n_chk;
  int n_fail;

  // Reference: a plain queue of held words, a sticky flag and the position inside the group.
  logic [DW-1:0] mq[$];
  logic          m_ovf;
  int            m_pos;

  typedef struct {
    logic          clr;
    logic [GW-1:0] gl;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    int            lvl;
    logic [DW-1:0] od;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic c, input logic [GW-1:0] gl, input logic iv,
                              input logic [DW-1:0] d, input logic ordy, input int lvl,
                              input logic [DW-1:0] od);
    vec_t v;
    v.clr = c; v.gl = gl; v.iv = iv; v.d = d; v.ordy = ordy; v.lvl = lvl; v.od = od;
    tbl.push_back(v);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_pos = 0;
  endfunction

  // Advance the reference by one clock using the inputs currently applied.
  function automatic void model_step();
    bit keep;
    bit was_full;
    int gl;
    gl = int'(grp_len);
    if (gl <= 1) begin
      keep  = bus.in_valid;
      m_pos = 0;
    end else begin
      if (m_pos >= gl) m_pos = 0;
      keep = bus.in_valid && (m_pos == 0);
      if (bus.in_valid) m_pos = (m_pos + 1) % gl;
    end
    if (clr) begin
      model_reset();
    end else begin
      was_full = (mq.size() == DEPTH);
      if (bus.out_ready && mq.size() != 0) void'(mq.pop_front());
      if (keep) begin
        if (was_full) m_ovf = 1'b1;
        else          mq.push_back(bus.in_data);
      end
    end
  endfunction

  task automatic cycle(input logic c, input logic [GW-1:0] gl, input logic iv,
                       input logic [DW-1:0] d, input logic ordy);
    clr           = c;
    grp_len       = gl;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    model_step();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic check_model(input string name);
    chk({name, ".level"}, 32'(level), 32'(mq.size()));
    chk({name, ".out_valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk({name, ".out_data"}, 32'(bus.out_data), 32'(mq[0]));
    chk({name, ".in_full"}, 32'(bus.in_full), 32'(mq.size() == DEPTH));
    chk({name, ".in_afull"}, 32'(bus.in_afull), 32'(mq.size() >= DEPTH - AFM));
    chk({name, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, GW'(1), 1'b1, DW'(base + i), 1'b0);
      check_model("fill");
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, GW'(1), 1'b0, '0, 1'b1);
      check_model("drain");
    end
  endtask

  initial begin
    logic          pv;
    logic [DW-1:0] pd;
    int            pr;
    int            gl;

    n_chk = 0;
    n_fail = 0;
    model_reset();
    rst = 1'b1;
    clr = 1'b0;
    grp_len = GW'(1);
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;

    #1;
    chk("reset.level", 32'(level), 0);
    chk("reset.out_valid", 32'(bus.out_valid), 0);
    chk("reset.out_data", 32'(bus.out_data), 0);
    chk("reset.in_full", 32'(bus.in_full), 0);
    chk("reset.in_afull", 32'(bus.in_afull), 0);
    chk("reset.overflow", 32'(overflow), 0);
    #11 rst = 1'b0;
    @(posedge bus_clk);
    #1;

    // Reset while holding data discards everything immediately.
    fill(3, 'h50);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst.level", 32'(level), 0);
    chk("midrst.out_valid", 32'(bus.out_valid), 0);
    chk("midrst.out_data", 32'(bus.out_data), 0);
    model_reset();
    @(negedge bus_clk);
    rst = 1'b0;
    @(posedge bus_clk);
    #1;
    check_model("postrst");

    // Vector table: pass-through, decimation by 4, group length change 4 -> 2.
    for (int i = 0; i < 5; i++) add(1'b0, GW'(1), 1'b1, DW'(i + 1), 1'b1, 1, DW'(i + 1));
    add(1'b0, GW'(1), 1'b0, '0, 1'b1, 0, '0);
    for (int w = 0; w < 12; w++) add(1'b0, GW'(4), 1'b1, DW'(w), 1'b0, w / 4 + 1, '0);
    add(1'b0, GW'(4), 1'b0, '0, 1'b1, 2, DW'(4));
    add(1'b0, GW'(4), 1'b0, '0, 1'b1, 1, DW'(8));
    add(1'b0, GW'(4), 1'b0, '0, 1'b1, 0, '0);
    add(1'b1, GW'(4), 1'b0, '0, 1'b0, 0, '0);
    add(1'b0, GW'(4), 1'b1, DW'(0), 1'b1, 1, DW'(0));
    add(1'b0, GW'(4), 1'b1, DW'(1), 1'b1, 0, '0);
    add(1'b0, GW'(4), 1'b1, DW'(2), 1'b1, 0, '0);
    add(1'b0, GW'(4), 1'b1, DW'(3), 1'b1, 0, '0);
    add(1'b0, GW'(4), 1'b1, DW'(4), 1'b1, 1, DW'(4));
    add(1'b0, GW'(4), 1'b1, DW'(5), 1'b1, 0, '0);
    add(1'b0, GW'(2), 1'b1, DW'(6), 1'b1, 1, DW'(6));
    add(1'b0, GW'(2), 1'b1, DW'(7), 1'b1, 0, '0);
    add(1'b0, GW'(2), 1'b1, DW'(8), 1'b1, 1, DW'(8));
    add(1'b0, GW'(2), 1'b0, '0, 1'b1, 0, '0);

    foreach (tbl[i]) begin
      cycle(tbl[i].clr, tbl[i].gl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk($sformatf("vec%0d.level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].lvl != 0));
      if (tbl[i].lvl != 0) chk($sformatf("vec%0d.out_data", i), 32'(bus.out_data), 32'(tbl[i].od));
      chk($sformatf("vec%0d.overflow", i), 32'(overflow), 0);
    end

    // Fill to full and one beyond with no consumer.
    cycle(1'b1, GW'(1), 1'b0, '0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      cycle(1'b0, GW'(1), 1'b1, DW'(i), 1'b0);
      check_model("ovf");
      if (i == 11) chk("ovf.afull_at11", 32'(bus.in_afull), 0);
      if (i == 12) chk("ovf.afull_at12", 32'(bus.in_afull), 1);
      if (i == 15) chk("ovf.full_at15", 32'(bus.in_full), 0);
      if (i == 16) chk("ovf.full_at16", 32'(bus.in_full), 1);
      if (i == 17) chk("ovf.sticky", 32'(overflow), 1);
    end
    for (int i = 1; i <= 16; i++) begin
      chk("ovf.drain_word", 32'(bus.out_data), 32'(i));
      cycle(1'b0, GW'(1), 1'b0, '0, 1'b1);
    end
    chk("ovf.empty", 32'(bus.out_valid), 0);
    check_model("ovf_end");

    // Push and pop together while full, then at half level.
    cycle(1'b1, GW'(1), 1'b0, '0, 1'b0);
    fill(16, 'h200);
    cycle(1'b0, GW'(1), 1'b1, DW'('h2ff), 1'b1);
    chk("simul.full_level", 32'(level), 15);
    chk("simul.full_ovf", 32'(overflow), 1);
    check_model("simul_full");
    drain(7);
    cycle(1'b0, GW'(1), 1'b1, DW'('h2aa), 1'b1);
    chk("simul.half_level", 32'(level), 8);
    check_model("simul_half");
    drain(9);

    // Alternating backpressure across a 32-word stream.
    cycle(1'b1, GW'(1), 1'b0, '0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      pv = bus.out_valid;
      pd = bus.out_data;
      cycle(1'b0, GW'(1), 1'b1, DW'('h100 + k), logic'(k % 2));
      if (pv && (k % 2) == 0) chk("bp.hold", 32'(bus.out_data), 32'(pd));
      check_model("bp");
    end
    drain(17);

    // Flush while partly full, overflowed and mid-group.
    cycle(1'b1, GW'(1), 1'b0, '0, 1'b0);
    fill(17, 'h300);
    drain(7);
    cycle(1'b0, GW'(3), 1'b1, DW'('h3a0), 1'b0);
    cycle(1'b0, GW'(3), 1'b1, DW'('h3a1), 1'b0);
    chk("clr.pre_level", 32'(level), 10);
    chk("clr.pre_ovf", 32'(overflow), 1);
    cycle(1'b1, GW'(3), 1'b1, DW'('h3a2), 1'b1);
    chk("clr.level", 32'(level), 0);
    chk("clr.out_valid", 32'(bus.out_valid), 0);
    chk("clr.overflow", 32'(overflow), 0);
    cycle(1'b0, GW'(3), 1'b1, DW'('habcd), 1'b0);
    chk("clr.first_kept_level", 32'(level), 1);
    chk("clr.first_kept_data", 32'(bus.out_data), 32'h0000abcd);
    check_model("clr_end");

    // Random traffic in phases of differing consumer speed.
    for (int ph = 0; ph < 15; ph++) begin
      pr = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 60 : 95);
      gl = (ph % 4 == 0) ? int'($urandom_range(2, 5)) : int'($urandom_range(0, 1));
      for (int k = 0; k < 200; k++) begin
        if ($urandom_range(0, 31) == 0) gl = int'($urandom_range(0, 6));
        cycle(logic'($urandom_range(0, 99) == 0), GW'(gl), logic'($urandom_range(0, 99) < 80),
              DW'($urandom), logic'(int'($urandom_range(0, 99)) < pr));
        check_model("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
